ram_arbiter: RTL and testbench
==============================

# ram_arbiter

- Shares the single-port 1024×16 byte-writable block RAM (10-bit address, 2-bit byte select, synchronous read, one-cycle read latency) between the CPU bus interface and the video fetch unit.
- Sequences every access through issue, capture and acknowledge phases, and drives the RAM address, select, write and data inputs from registers.
- Returns read data to the requester that won arbitration.

## Interface
Parameters:
- none; widths are fixed by the RAM (10-bit word address, 16-bit data).

Ports (the clock is `CLK`; the reset is synchronous and active-high, named `RST`):
- CLK  in  1  system clock; the RAM is clocked by the same net
- RST  in  1  synchronous, active-high reset
- C_REQ  in  1  CPU access request; held until C_ACK
- C_ADDR  in  10  CPU word address
- C_SEL  in  2  CPU byte select; [0] = low byte, [1] = high byte
- C_WR  in  1  1 = write, 0 = read
- C_DI  in  16  CPU write data
- C_DO  out  16  CPU read data, registered
- C_ACK  out  1  one-cycle completion strobe to the CPU
- V_REQ  in  1  video read request; held until V_ACK
- V_ADDR  in  10  video word address
- V_DO  out  16  video read data, registered
- V_ACK  out  1  one-cycle completion strobe to video
- R_ADDR  out  10  RAM address
- R_SEL  out  2  RAM byte select
- R_WR  out  1  RAM write strobe
- R_DI  out  16  RAM write data
- R_DO  in  16  RAM read data

## Operation
The controller is a four-state FSM.

- IDLE
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner and latch its C_/V_ inputs into R_ADDR, R_SEL, R_WR and R_DI, plus an internal owner bit. Go to ISSUE.
  - Video access: R_SEL=11, R_WR=0, R_DI=0.
  - CPU access: R_SEL=C_SEL, R_WR=C_WR, R_DI=C_DI.
- ISSUE
  - The RAM samples R_* at the end of this cycle.
  - On exit, R_WR is cleared to 0. Go to CAPTURE.
- CAPTURE
  - R_DO is valid in this cycle.
  - At the closing edge, copy R_DO into the owner's DO, but only for a read. A CPU write leaves C_DO unchanged.
  - Go to ACK.
- ACK
  - Assert the owner's ACK for exactly this cycle. Go to IDLE.

Requester rules:
- A requester samples its ACK at the edge that ends the ACK cycle and drops REQ. REQ is therefore low in the following IDLE cycle unless a new access is wanted.
- Request inputs must stay stable from REQ rise until ACK.
- The block does not check the request inputs while busy; a REQ that rises during a busy cycle waits in IDLE for the next arbitration.

Other rules:
- Default arbitration is fixed priority: on a tie, video wins.
- A CPU write with C_SEL=00 runs the full sequence and ACKs, but modifies no byte.
- C_DO and V_DO hold their value until the owner's next read completes.
- Reset: RST forces IDLE from any state, including mid-access.
  - At the reset edge all outputs go to 0: R_ADDR, R_SEL, R_WR, R_DI, C_DO, V_DO, C_ACK, V_ACK.
  - An access aborted by reset produces no ACK.
  - A write aborted during ISSUE may or may not have been sampled by the RAM.

## Timing
- Latency: REQ high in IDLE cycle n gives ISSUE at n+1, CAPTURE at n+2, ACK at n+3, and IDLE at n+4.
- DO is valid from cycle n+3 onward.
- Peak throughput is one access per 4 cycles.
- Back-to-back access by the other requester: its REQ pending during cycle n+4 is granted that cycle, and its ACK comes at n+7.
- R_WR is high only during the ISSUE cycle of a CPU write.
- No combinational path runs from any input to any output.

## Configuration
- `RAMARB_RR_EN` defined: round-robin arbitration on ties.
  - A last-grant register records the last winner; on a tie, the other requester wins.
  - Reset value of the register is "CPU last", so the first tie after reset goes to video.
  - With only one requester active, that requester wins and the register updates.
- `RAMARB_RR_EN` undefined: fixed priority, video always wins ties. The CPU can be starved by continuous video requests.

## Test plan
- Reset: assert RST for 2 cycles mid-stream → every output is 0 the cycle after RST, and the FSM is in IDLE.
- CPU full-word write, then read back:
  - Write C_ADDR=0x005, C_SEL=11, C_DI=0xA55A → C_ACK 3 cycles after REQ; R_WR high for exactly 1 cycle; C_DO unchanged.
  - Read the same address → C_DO=0xA55A at the ACK cycle.
- Byte write: write C_SEL=01, C_DI=0x1234 to 0x005, then read → C_DO=0xA534. Then write C_SEL=10, C_DI=0x7700 and read → 0x7734.
- Tie, fixed priority: V_REQ and C_REQ rise together at cycle n → V_ACK at n+3, C_ACK at n+7. With RAMARB_RR_EN, repeated ties alternate V, C, V, C.
- Reset mid-access: CPU write to 0x010 with RST asserted during CAPTURE → no C_ACK, R_WR=0, next V_REQ is served normally with 3-cycle latency.
- Video read: V_ADDR=0x005 after the byte-write test → V_DO=0x7734 at n+3; C_DO is not disturbed.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
//
// Bundles every bus signal around the RAM arbiter: the CPU request channel,
// the video request channel and the single-port RAM channel.
//
//   CPU side    : C_REQ, C_ADDR[9:0], C_SEL[1:0], C_WR, C_DI[15:0] (to arbiter)
//                 C_DO[15:0], C_ACK                                (from arbiter)
//   Video side  : V_REQ, V_ADDR[9:0]                               (to arbiter)
//                 V_DO[15:0], V_ACK                                (from arbiter)
//   RAM side    : R_ADDR[9:0], R_SEL[1:0], R_WR, R_DI[15:0]        (from arbiter)
//                 R_DO[15:0]                                       (to arbiter)
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding system (requesters plus the RAM)
// ---------------------------------------------------------------------------
interface ram_arbiter_if;
  logic        C_REQ;
  logic [9:0]  C_ADDR;
  logic [1:0]  C_SEL;
  logic        C_WR;
  logic [15:0] C_DI;
  logic [15:0] C_DO;
  logic        C_ACK;

  logic        V_REQ;
  logic [9:0]  V_ADDR;
  logic [15:0] V_DO;
  logic        V_ACK;

  logic [9:0]  R_ADDR;
  logic [1:0]  R_SEL;
  logic        R_WR;
  logic [15:0] R_DI;
  logic [15:0] R_DO;

  modport slave (
    input  C_REQ, C_ADDR, C_SEL, C_WR, C_DI, V_REQ, V_ADDR, R_DO,
    output C_DO, C_ACK, V_DO, V_ACK, R_ADDR, R_SEL, R_WR, R_DI
  );

  modport master (
    output C_REQ, C_ADDR, C_SEL, C_WR, C_DI, V_REQ, V_ADDR, R_DO,
    input  C_DO, C_ACK, V_DO, V_ACK, R_ADDR, R_SEL, R_WR, R_DI
  );
endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares one 1024x16 byte-writable single-port block RAM (one-cycle read
// latency) between the CPU and the video fetch unit. Every access walks
// IDLE -> ISSUE -> CAPTURE -> ACK, so one access completes every 4 cycles.
// All outputs come straight from registers.
//
// Ports:
//   CLK  - system clock, shared with the RAM
//   RST  - synchronous active-high reset; aborts any access without an ACK
//   bus  - ram_arbiter_if.slave: CPU channel, video channel and RAM channel
//
// Build option:
//   RAMARB_RR_EN - when defined, ties are resolved round-robin using a
//                  last-grant register (resets to "CPU last"); otherwise
//                  video always wins a tie.
// ---------------------------------------------------------------------------
module ram_arbiter (
  input logic          CLK,
  input logic          RST,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t      state_q, state_d;
  logic [9:0]  rAddr_q, rAddr_d;
  logic [1:0]  rSel_q, rSel_d;
  logic        rWr_q, rWr_d;
  logic [15:0] rDi_q, rDi_d;
  logic [15:0] cDo_q, cDo_d;
  logic [15:0] vDo_q, vDo_d;
  logic        cAck_q, cAck_d;
  logic        vAck_q, vAck_d;
  // Owner of the access in flight (1 = video) and whether it is a write.
  // The write flag is kept separately because R_WR drops after ISSUE.
  logic        ownerVideo_q, ownerVideo_d;
  logic        isWrite_q, isWrite_d;
  logic        anyReq;
  logic        grantVideo;

  assign anyReq = bus.C_REQ | bus.V_REQ;

`ifdef RAMARB_RR_EN
  // Round-robin: lastCpu_q remembers who was granted last. On a tie the
  // requester that did not go last wins; a lone requester always wins.
  logic lastCpu_q, lastCpu_d;

  assign grantVideo = bus.V_REQ & (~bus.C_REQ | lastCpu_q);

  always_comb begin
    lastCpu_d = lastCpu_q;
    if (state_q == IDLE && anyReq) begin
      lastCpu_d = ~grantVideo;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lastCpu_q <= 1'b1;
    end else begin
      lastCpu_q <= lastCpu_d;
    end
  end
`else
  // Fixed priority: video wins every tie.
  assign grantVideo = bus.V_REQ;
`endif

  // State register of the access sequencer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decisions. Requests are only looked at in IDLE;
  // the winner's inputs are latched there so nothing combinational reaches
  // the RAM or the requesters.
  always_comb begin
    state_d      = state_q;
    rAddr_d      = rAddr_q;
    rSel_d       = rSel_q;
    rWr_d        = rWr_q;
    rDi_d        = rDi_q;
    cDo_d        = cDo_q;
    vDo_d        = vDo_q;
    cAck_d       = 1'b0;
    vAck_d       = 1'b0;
    ownerVideo_d = ownerVideo_q;
    isWrite_d    = isWrite_q;

    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d      = ISSUE;
          ownerVideo_d = grantVideo;
          if (grantVideo) begin
            rAddr_d   = bus.V_ADDR;
            rSel_d    = 2'b11;
            rWr_d     = 1'b0;
            rDi_d     = 16'h0000;
            isWrite_d = 1'b0;
          end else begin
            rAddr_d   = bus.C_ADDR;
            rSel_d    = bus.C_SEL;
            rWr_d     = bus.C_WR;
            rDi_d     = bus.C_DI;
            isWrite_d = bus.C_WR;
          end
        end
      end
      ISSUE: begin
        // The RAM takes the command at the end of this cycle.
        rWr_d   = 1'b0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // R_DO is valid now; only reads update the owner's data register.
        if (!isWrite_q) begin
          if (ownerVideo_q) begin
            vDo_d = bus.R_DO;
          end else begin
            cDo_d = bus.R_DO;
          end
        end
        cAck_d  = ~ownerVideo_q;
        vAck_d  = ownerVideo_q;
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and bookkeeping registers; reset clears every visible output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rAddr_q      <= '0;
      rSel_q       <= '0;
      rWr_q        <= 1'b0;
      rDi_q        <= '0;
      cDo_q        <= '0;
      vDo_q        <= '0;
      cAck_q       <= 1'b0;
      vAck_q       <= 1'b0;
      ownerVideo_q <= 1'b0;
      isWrite_q    <= 1'b0;
    end else begin
      rAddr_q      <= rAddr_d;
      rSel_q       <= rSel_d;
      rWr_q        <= rWr_d;
      rDi_q        <= rDi_d;
      cDo_q        <= cDo_d;
      vDo_q        <= vDo_d;
      cAck_q       <= cAck_d;
      vAck_q       <= vAck_d;
      ownerVideo_q <= ownerVideo_d;
      isWrite_q    <= isWrite_d;
    end
  end

  assign bus.R_ADDR = rAddr_q;
  assign bus.R_SEL  = rSel_q;
  assign bus.R_WR   = rWr_q;
  assign bus.R_DI   = rDi_q;
  assign bus.C_DO   = cDo_q;
  assign bus.C_ACK  = cAck_q;
  assign bus.V_DO   = vDo_q;
  assign bus.V_ACK  = vAck_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Drives random CPU, video and simultaneous requests into ram_arbiter, with
// a behavioural RAM attached, and compares acknowledge timing and returned
// data against a reference model: a shadow memory array plus the expected
// data-out values of each requester and the tie-break rule.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic memClear = 1'b1;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port RAM: byte-enabled write, registered read.
  logic [15:0] ramMem [1024];
  always @(posedge CLK) begin
    if (memClear) begin
      for (int i = 0; i < 1024; i++) ramMem[i] <= 16'h0000;
    end else if (bus.R_WR) begin
      if (bus.R_SEL[0]) ramMem[bus.R_ADDR][7:0]  <= bus.R_DI[7:0];
      if (bus.R_SEL[1]) ramMem[bus.R_ADDR][15:8] <= bus.R_DI[15:8];
    end
    bus.R_DO <= ramMem[bus.R_ADDR];
  end

  // Reference model state.
  logic [15:0] refMem [1024];
  logic [15:0] cdoModel;
  logic [15:0] vdoModel;
  bit          lastGrantCpu;

  int checkCount = 0;
  int errorCount = 0;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] mergeBytes(input logic [15:0] old, input logic [1:0] sel,
                                             input logic [15:0] d);
    return {sel[1] ? d[15:8] : old[15:8], sel[0] ? d[7:0] : old[7:0]};
  endfunction

  // Model of one CPU access taking effect.
  task automatic modelCpu(input logic wr, input logic [9:0] addr, input logic [1:0] sel,
                          input logic [15:0] di);
    if (wr) refMem[addr] = mergeBytes(refMem[addr], sel, di);
    else    cdoModel = refMem[addr];
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".R_ADDR"}, 32'(bus.R_ADDR), 0);
    checkOutput({tag, ".R_SEL"},  32'(bus.R_SEL),  0);
    checkOutput({tag, ".R_WR"},   32'(bus.R_WR),   0);
    checkOutput({tag, ".R_DI"},   32'(bus.R_DI),   0);
    checkOutput({tag, ".C_DO"},   32'(bus.C_DO),   0);
    checkOutput({tag, ".V_DO"},   32'(bus.V_DO),   0);
    checkOutput({tag, ".C_ACK"},  32'(bus.C_ACK),  0);
    checkOutput({tag, ".V_ACK"},  32'(bus.V_ACK),  0);
  endtask

  // Single requester access starting in an IDLE cycle; checks latency,
  // RAM command, write-strobe width, returned data and one-cycle ACK.
  task automatic applyStimulus(input bit isVideo, input logic wr, input logic [9:0] addr,
                               input logic [1:0] sel, input logic [15:0] di);
    int lat = 0;
    int wrCycles = 0;
    logic ackSeen = 1'b0;
    if (isVideo) begin
      bus.V_REQ = 1'b1; bus.V_ADDR = addr;
    end else begin
      bus.C_REQ = 1'b1; bus.C_ADDR = addr; bus.C_SEL = sel; bus.C_WR = wr; bus.C_DI = di;
    end
    while (!ackSeen && lat < 20) begin
      tick();
      lat++;
      if (bus.R_WR) wrCycles++;
      if (lat == 1) begin
        checkOutput("issueAddr", 32'(bus.R_ADDR), 32'(addr));
        checkOutput("issueSel",  32'(bus.R_SEL),  isVideo ? 32'd3 : 32'(sel));
      end
      ackSeen = isVideo ? bus.V_ACK : bus.C_ACK;
    end
    if (isVideo) begin
      vdoModel = refMem[addr];
      lastGrantCpu = 1'b0;
    end else begin
      modelCpu(wr, addr, sel, di);
      lastGrantCpu = 1'b1;
    end
    checkOutput(isVideo ? "vidLatency" : "cpuLatency", 32'(lat), 3);
    checkOutput("wrStrobeCycles", 32'(wrCycles), (!isVideo && wr) ? 32'd1 : 32'd0);
    checkOutput("C_DO", 32'(bus.C_DO), 32'(cdoModel));
    checkOutput("V_DO", 32'(bus.V_DO), 32'(vdoModel));
    bus.V_REQ = 1'b0;
    bus.C_REQ = 1'b0;
    tick();
    checkOutput("ackOneCycle", 32'({bus.C_ACK, bus.V_ACK}), 0);
  endtask

  // Both requesters raise REQ in the same IDLE cycle.
  task automatic tieAccess(input logic wr, input logic [9:0] cAddr, input logic [1:0] sel,
                           input logic [15:0] di, input logic [9:0] vAddr);
    int vAt = -1;
    int cAt = -1;
    bit videoFirst;
    logic [15:0] expV;
    logic [15:0] expC;
`ifdef RAMARB_RR_EN
    videoFirst = lastGrantCpu;
`else
    videoFirst = 1'b1;
`endif
    if (videoFirst) begin
      vdoModel = refMem[vAddr];
      modelCpu(wr, cAddr, sel, di);
    end else begin
      modelCpu(wr, cAddr, sel, di);
      vdoModel = refMem[vAddr];
    end
    expV = vdoModel;
    expC = cdoModel;
    lastGrantCpu = videoFirst;
    bus.C_REQ = 1'b1; bus.C_ADDR = cAddr; bus.C_SEL = sel; bus.C_WR = wr; bus.C_DI = di;
    bus.V_REQ = 1'b1; bus.V_ADDR = vAddr;
    for (int cyc = 1; cyc <= 12 && (vAt < 0 || cAt < 0); cyc++) begin
      tick();
      if (bus.V_ACK) begin
        vAt = cyc;
        checkOutput("tieV_DO", 32'(bus.V_DO), 32'(expV));
        bus.V_REQ = 1'b0;
      end
      if (bus.C_ACK) begin
        cAt = cyc;
        checkOutput("tieC_DO", 32'(bus.C_DO), 32'(expC));
        bus.C_REQ = 1'b0;
      end
    end
    bus.V_REQ = 1'b0;
    bus.C_REQ = 1'b0;
    checkOutput("tieVackCycle", 32'(vAt), videoFirst ? 32'd3 : 32'd7);
    checkOutput("tieCackCycle", 32'(cAt), videoFirst ? 32'd7 : 32'd3);
    tick();
  endtask

  // CPU write aborted by a two-cycle reset asserted during CAPTURE.
  task automatic resetMidAccess();
    int acks = 0;
    bus.C_REQ = 1'b1; bus.C_ADDR = 10'h010; bus.C_SEL = 2'b11; bus.C_WR = 1'b1;
    bus.C_DI = 16'hBEEF;
    tick();
    acks += int'(bus.C_ACK);
    tick();
    acks += int'(bus.C_ACK);
    RST = 1'b1;
    bus.C_REQ = 1'b0;
    tick();
    checkAllZero("rstMid");
    tick();
    acks += int'(bus.C_ACK);
    RST = 1'b0;
    // The RAM already took the write at the end of ISSUE.
    refMem[10'h010] = 16'hBEEF;
    cdoModel = 16'h0000;
    vdoModel = 16'h0000;
    lastGrantCpu = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      acks += int'(bus.C_ACK);
    end
    checkOutput("rstNoAck", 32'(acks), 0);
    applyStimulus(1'b1, 1'b0, 10'h010, 2'b11, 16'h0);
  endtask

  initial begin
    logic [9:0]  addr;
    logic [9:0]  addr2;
    logic [1:0]  sel;
    logic [15:0] data;
    int          kind;
    bus.C_REQ = 1'b0; bus.C_ADDR = '0; bus.C_SEL = '0; bus.C_WR = 1'b0; bus.C_DI = '0;
    bus.V_REQ = 1'b0; bus.V_ADDR = '0;
    for (int i = 0; i < 1024; i++) refMem[i] = 16'h0000;
    cdoModel = 16'h0000;
    vdoModel = 16'h0000;
    lastGrantCpu = 1'b1;

    RST = 1'b1;
    tick(); tick();
    memClear = 1'b0;
    tick();
    checkAllZero("reset");
    RST = 1'b0;
    tick();

    // Directed: full write, read back, byte writes, video read.
    applyStimulus(1'b0, 1'b1, 10'h005, 2'b11, 16'hA55A);
    applyStimulus(1'b0, 1'b0, 10'h005, 2'b11, 16'h0000);
    checkOutput("readBackA55A", 32'(bus.C_DO), 32'h0000_A55A);
    applyStimulus(1'b0, 1'b1, 10'h005, 2'b01, 16'h1234);
    applyStimulus(1'b0, 1'b0, 10'h005, 2'b11, 16'h0000);
    checkOutput("byteLowA534", 32'(bus.C_DO), 32'h0000_A534);
    applyStimulus(1'b0, 1'b1, 10'h005, 2'b10, 16'h7700);
    applyStimulus(1'b0, 1'b0, 10'h005, 2'b11, 16'h0000);
    checkOutput("byteHigh7734", 32'(bus.C_DO), 32'h0000_7734);
    applyStimulus(1'b1, 1'b0, 10'h005, 2'b11, 16'h0000);
    checkOutput("videoRead7734", 32'(bus.V_DO), 32'h0000_7734);
    // Write with no byte enables: completes but changes nothing.
    applyStimulus(1'b0, 1'b1, 10'h005, 2'b00, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, 10'h005, 2'b11, 16'h0000);

    // Repeated ties.
    for (int i = 0; i < 4; i++) tieAccess(1'b0, 10'h005, 2'b11, 16'h0, 10'h005);

    resetMidAccess();

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      kind  = int'($urandom_range(0, 3));
      addr  = 10'($urandom_range(0, 7));
      addr2 = 10'($urandom_range(0, 7));
      sel   = 2'($urandom_range(0, 3));
      data  = 16'($urandom);
      case (kind)
        0: applyStimulus(1'b0, 1'b1, addr, sel, data);
        1: applyStimulus(1'b0, 1'b0, addr, sel, data);
        2: applyStimulus(1'b1, 1'b0, addr, 2'b11, 16'h0);
        default: tieAccess(1'($urandom_range(0, 1)), addr, sel, data, addr2);
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
